// File: rtl/joystick_dir_filter.sv
// Poll scheduler and consumer for an MCP3008 SPI ADC driver: box-averages X/Y samples and
// turns the averages into a debounced 4-way joystick direction with deadzone and hysteresis.
module joystick_dir_filter #(
    parameter int unsigned POLL_CYCLES    = 100000,
    parameter int unsigned TIMEOUT_CYCLES = 1000,
    parameter int unsigned AVG_LOG2       = 2,
    parameter int unsigned DEADZONE       = 100,
    parameter int unsigned HYST           = 16
) (
    input  logic       clk,
    input  logic       rst,
    output logic       adc_start,
    input  logic [9:0] adc_x,
    input  logic [9:0] adc_y,
    input  logic       adc_valid,
    output logic [9:0] x_avg,
    output logic [9:0] y_avg,
    output logic       avg_valid,
    output logic [3:0] dir,
    output logic       dir_changed,
    output logic       adc_fault
);

    localparam int unsigned PollW = $clog2(POLL_CYCLES);
    localparam int unsigned ToW   = $clog2(TIMEOUT_CYCLES);
    localparam int unsigned AccW  = 10 + AVG_LOG2;
    localparam int unsigned CntW  = AVG_LOG2 + 1;

    localparam logic [PollW-1:0] PollLast = PollW'(POLL_CYCLES - 1);
    localparam logic [ToW-1:0]   ToLast   = ToW'(TIMEOUT_CYCLES - 1);
    localparam logic [CntW-1:0]  CntLast  = CntW'((1 << AVG_LOG2) - 1);

    localparam logic [10:0] HiEnter = 11'(512 + DEADZONE + HYST);
    localparam logic [10:0] HiExit  = 11'(512 + DEADZONE);
    localparam logic [10:0] LoEnter = 11'(512 - DEADZONE - HYST);
    localparam logic [10:0] LoExit  = 11'(512 - DEADZONE);

    typedef enum logic [1:0] {StWaitTick, StWaitData, StUpdate} state_e;
    typedef enum logic [1:0] {AxCentre, AxPos, AxNeg} axis_e;

    state_e            state_q, state_d;
    logic [PollW-1:0]  poll_q;
    logic [ToW-1:0]    to_q, to_d;
    logic [AccW-1:0]   acc_x_q, acc_x_d, acc_y_q, acc_y_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [9:0]        x_avg_q, x_avg_d, y_avg_q, y_avg_d;
    axis_e             ax_q, ax_d, ay_q, ay_d;
    logic [3:0]        dir_q, dir_d;
    logic              avg_valid_q, avg_valid_d;
    logic              changed_q, changed_d;
    logic              fault_q, fault_d;
    logic              tick;
    logic              to_expired;
    logic [9:0]        x_mean, y_mean;

    // Hysteresis: entering a side needs DEADZONE+HYST, leaving it only drops below DEADZONE.
    function automatic axis_e axis_next(input axis_e cur, input logic [9:0] avg);
        logic [10:0] a;
        a = {1'b0, avg};
        if (a >= HiEnter)                     axis_next = AxPos;
        else if (a <= LoEnter)                axis_next = AxNeg;
        else if (cur == AxPos && a >= HiExit) axis_next = AxPos;
        else if (cur == AxNeg && a <= LoExit) axis_next = AxNeg;
        else                                  axis_next = AxCentre;
    endfunction

    assign tick       = (poll_q == PollLast);
    assign to_expired = (to_q == ToLast);
    assign x_mean     = acc_x_q[AccW-1:AVG_LOG2];
    assign y_mean     = acc_y_q[AccW-1:AVG_LOG2];

    always_ff @(posedge clk) begin
        if (rst) state_q <= StWaitTick;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StWaitTick: if (tick) state_d = StWaitData;
            StWaitData: begin
                if (adc_valid)       state_d = (cnt_q == CntLast) ? StUpdate : StWaitTick;
                else if (to_expired) state_d = StWaitTick;
            end
            StUpdate:   state_d = StWaitTick;
            default:    state_d = StWaitTick;
        endcase
    end

    always_comb begin
        adc_start = 1'b0;
        if (state_q == StWaitTick && tick) adc_start = 1'b1;
    end

    always_comb begin
        to_d        = (state_q == StWaitData) ? to_q + ToW'(1) : '0;
        acc_x_d     = acc_x_q;
        acc_y_d     = acc_y_q;
        cnt_d       = cnt_q;
        fault_d     = fault_q;
        x_avg_d     = x_avg_q;
        y_avg_d     = y_avg_q;
        ax_d        = ax_q;
        ay_d        = ay_q;
        dir_d       = dir_q;
        avg_valid_d = 1'b0;
        changed_d   = 1'b0;
        case (state_q)
            StWaitData: begin
                // A sample arriving on the expiry cycle takes priority over the timeout.
                if (adc_valid) begin
                    acc_x_d = acc_x_q + AccW'(adc_x);
                    acc_y_d = acc_y_q + AccW'(adc_y);
                    cnt_d   = cnt_q + CntW'(1);
                    fault_d = 1'b0;
                end else if (to_expired) begin
                    acc_x_d = '0;
                    acc_y_d = '0;
                    cnt_d   = '0;
                    fault_d = 1'b1;
                end
            end
            StUpdate: begin
                x_avg_d     = x_mean;
                y_avg_d     = y_mean;
                ax_d        = axis_next(ax_q, x_mean);
                ay_d        = axis_next(ay_q, y_mean);
                dir_d       = {ay_d == AxPos, ay_d == AxNeg, ax_d == AxNeg, ax_d == AxPos};
                changed_d   = (dir_d != dir_q);
                avg_valid_d = 1'b1;
                acc_x_d     = '0;
                acc_y_d     = '0;
                cnt_d       = '0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            poll_q      <= '0;
            to_q        <= '0;
            acc_x_q     <= '0;
            acc_y_q     <= '0;
            cnt_q       <= '0;
            fault_q     <= 1'b0;
            x_avg_q     <= 10'd512;
            y_avg_q     <= 10'd512;
            ax_q        <= AxCentre;
            ay_q        <= AxCentre;
            dir_q       <= '0;
            avg_valid_q <= 1'b0;
            changed_q   <= 1'b0;
        end else begin
            poll_q      <= tick ? '0 : poll_q + PollW'(1);
            to_q        <= to_d;
            acc_x_q     <= acc_x_d;
            acc_y_q     <= acc_y_d;
            cnt_q       <= cnt_d;
            fault_q     <= fault_d;
            x_avg_q     <= x_avg_d;
            y_avg_q     <= y_avg_d;
            ax_q        <= ax_d;
            ay_q        <= ay_d;
            dir_q       <= dir_d;
            avg_valid_q <= avg_valid_d;
            changed_q   <= changed_d;
        end
    end

    assign x_avg       = x_avg_q;
    assign y_avg       = y_avg_q;
    assign avg_valid   = avg_valid_q;
    assign dir         = dir_q;
    assign dir_changed = changed_q;
    assign adc_fault   = fault_q;

endmodule
